// File: rtl/gfx_cmd_scheduler.sv
// gfx_cmd_scheduler: queues fill / ROM-blit rectangle commands and launches
// them one at a time into graphics_processor via gp_en / gp_* / gp_finish.
// Optional build macro GFX_SCHED_VBLANK_GATE_EN adds a vblank input; launches
// then only happen while vblank is high.
`timescale 1ns/1ps
module gfx_cmd_scheduler #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_opcode,
  input  logic [9:0]                 cmd_tl_x,
  input  logic [8:0]                 cmd_tl_y,
  input  logic [9:0]                 cmd_br_x,
  input  logic [8:0]                 cmd_br_y,
  input  logic [11:0]                cmd_arg,
  input  logic                       flush,
  input  logic                       err_clr,
  output logic                       gp_en,
  output logic                       gp_opcode,
  output logic [9:0]                 gp_tl_x,
  output logic [8:0]                 gp_tl_y,
  output logic [9:0]                 gp_br_x,
  output logic [8:0]                 gp_br_y,
  output logic [11:0]                gp_arg,
  input  logic                       gp_finish,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       err_invalid,
  output logic [CNT_W-1:0]           done_count
`ifdef GFX_SCHED_VBLANK_GATE_EN
  ,
  input  logic                       vblank
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = 51;
  localparam logic [10:0] WIDTH_L  = 11'(WIDTH);
  localparam logic [9:0]  HEIGHT_L = 10'(HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RELEASE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [CW-1:0]   mem_q [DEPTH];
  logic [CW-1:0]   gp_cmd_q, gp_cmd_d;
  logic            gp_en_q, gp_en_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] done_q, done_d;

  logic            full;
  logic            push;
  logic            cmd_legal;
  logic            wr_en;
  logic            pop;
  logic            launch_ok;
  logic [CW-1:0]   cmd_word;

  // Handshake, legality check and FIFO bookkeeping
  always_comb begin
    full      = (level_q == LW'(DEPTH));
    push      = cmd_valid && !full;
    cmd_legal = (cmd_tl_x <= cmd_br_x) && (cmd_tl_y <= cmd_br_y) &&
                ({1'b0, cmd_br_x} < WIDTH_L) && ({1'b0, cmd_br_y} < HEIGHT_L);
    // flush wins over a same-cycle push: the command is handshaken but dropped
    wr_en     = push && cmd_legal && !flush;
    cmd_word  = {cmd_opcode, cmd_tl_x, cmd_tl_y, cmd_br_x, cmd_br_y, cmd_arg};
`ifdef GFX_SCHED_VBLANK_GATE_EN
    launch_ok = vblank;
`else
    launch_ok = 1'b1;
`endif
    pop       = (state_q == S_IDLE) && (level_q != '0) && !flush && launch_ok;

    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      level_d  = level_q + LW'(wr_en) - LW'(pop);
    end

    if (push && !cmd_legal) err_d = 1'b1;
    else if (err_clr)       err_d = 1'b0;
    else                    err_d = err_q;
  end

  // Launch / run / release sequencing towards the engine
  always_comb begin
    state_d  = state_q;
    gp_en_d  = gp_en_q;
    gp_cmd_d = gp_cmd_q;
    done_d   = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          gp_cmd_d = mem_q[rd_ptr_q];
          gp_en_d  = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (gp_finish) begin
          gp_en_d = 1'b0;
          done_d  = done_q + CNT_W'(1);
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM, pointers, registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      gp_cmd_q <= '0;
      gp_en_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      gp_cmd_q <= gp_cmd_d;
      gp_en_q  <= gp_en_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  // Command storage; contents need no reset since the pointers qualify them
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= cmd_word;
  end

  assign cmd_ready   = !full;
  assign gp_en       = gp_en_q;
  assign {gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg} = gp_cmd_q;
  assign busy        = (state_q != S_IDLE) || (level_q != '0);
  assign level       = level_q;
  assign err_invalid = err_q;
  assign done_count  = done_q;

endmodule

// File: tb/tb_gfx_cmd_scheduler.sv
// Self-checking bench for gfx_cmd_scheduler: directed scenarios followed by
// random traffic, every cycle compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_gfx_cmd_scheduler;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_opcode = 1'b0;
  logic [9:0]  cmd_tl_x = '0;
  logic [8:0]  cmd_tl_y = '0;
  logic [9:0]  cmd_br_x = '0;
  logic [8:0]  cmd_br_y = '0;
  logic [11:0] cmd_arg = '0;
  logic        flush = 1'b0;
  logic        err_clr = 1'b0;
  logic        gp_en;
  logic        gp_opcode;
  logic [9:0]  gp_tl_x;
  logic [8:0]  gp_tl_y;
  logic [9:0]  gp_br_x;
  logic [8:0]  gp_br_y;
  logic [11:0] gp_arg;
  logic        gp_finish = 1'b0;
  logic        busy;
  logic [3:0]  level;
  logic        err_invalid;
  logic [15:0] done_count;

  gfx_cmd_scheduler #(.DEPTH(DEPTH), .WIDTH(640), .HEIGHT(480), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_tl_x(cmd_tl_x), .cmd_tl_y(cmd_tl_y),
    .cmd_br_x(cmd_br_x), .cmd_br_y(cmd_br_y), .cmd_arg(cmd_arg),
    .flush(flush), .err_clr(err_clr), .gp_en(gp_en), .gp_opcode(gp_opcode),
    .gp_tl_x(gp_tl_x), .gp_tl_y(gp_tl_y), .gp_br_x(gp_br_x), .gp_br_y(gp_br_y),
    .gp_arg(gp_arg), .gp_finish(gp_finish), .busy(busy), .level(level),
    .err_invalid(err_invalid), .done_count(done_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: pending queue plus scheduler phase flags
  logic [50:0] mq[$];
  bit          m_run, m_rel, m_en, m_err, m_pushed;
  logic [50:0] m_gp;
  logic [15:0] m_done;
  int          m_age;

  function automatic logic [50:0] pack(input logic op, input logic [9:0] tlx, input logic [8:0] tly,
                                       input logic [9:0] brx, input logic [8:0] bry, input logic [11:0] arg);
    return {op, tlx, tly, brx, bry, arg};
  endfunction

  function automatic bit legal(input logic [9:0] tlx, input logic [8:0] tly,
                               input logic [9:0] brx, input logic [8:0] bry);
    return (tlx <= brx) && (tly <= bry) && (brx < 10'd640) && (bry < 9'd480);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_run = 0; m_rel = 0; m_en = 0; m_err = 0; m_pushed = 0;
    m_gp = '0; m_done = '0; m_age = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    bit ready, push, ok, launch;
    ready  = mq.size() < DEPTH;
    push   = cmd_valid && ready;
    ok     = legal(cmd_tl_x, cmd_tl_y, cmd_br_x, cmd_br_y);
    launch = !m_run && !m_rel && (mq.size() != 0) && !flush;
    m_pushed = push;
    if (launch) begin
      m_gp = mq.pop_front(); m_en = 1; m_run = 1; m_age = 0;
    end else if (m_run) begin
      if (gp_finish) begin m_en = 0; m_run = 0; m_rel = 1; m_done = m_done + 16'd1; end
      else m_age++;
    end else if (m_rel) begin
      m_rel = 0;
    end
    if (flush) mq.delete();
    else if (push && ok) mq.push_back(pack(cmd_opcode, cmd_tl_x, cmd_tl_y, cmd_br_x, cmd_br_y, cmd_arg));
    if (push && !ok) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  task automatic compare_all();
    check("cmd_ready", 64'(cmd_ready), 64'(mq.size() < DEPTH));
    check("level", 64'(level), 64'(mq.size()));
    check("busy", 64'(busy), 64'(m_run || m_rel || mq.size() != 0));
    check("gp_en", 64'(gp_en), 64'(m_en));
    check("gp_cmd", 64'({gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg}), 64'(m_gp));
    check("done_count", 64'(done_count), 64'(m_done));
    check("err_invalid", 64'(err_invalid), 64'(m_err));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_cmd(input logic op, input logic [9:0] tlx, input logic [8:0] tly,
                         input logic [9:0] brx, input logic [8:0] bry, input logic [11:0] arg);
    cmd_valid = 1; cmd_opcode = op; cmd_tl_x = tlx; cmd_tl_y = tly;
    cmd_br_x = brx; cmd_br_y = bry; cmd_arg = arg;
  endtask

  // Let the engine finish each command once it has run for lat cycles
  task automatic drain(input int lat);
    cmd_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      if (mq.size() == 0 && !m_run && !m_rel) break;
      gp_finish = m_en && (m_age >= lat);
      step();
    end
    gp_finish = 0;
    check("drain_busy", 64'(busy), 64'd0);
  endtask

  int base;
  int k;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1;
    step();

    // Single fill command, engine finishes after 8 stalled cycles
    set_cmd(0, 10'd0, 9'd0, 10'd3, 9'd1, 12'hF00);
    step();
    cmd_valid = 0;
    step();
    check("t2_en_high", 64'(gp_en), 64'd1);
    check("t2_gp_cmd", 64'({gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg}),
          64'(pack(0, 10'd0, 9'd0, 10'd3, 9'd1, 12'hF00)));
    repeat (8) step();
    gp_finish = 1;
    step();
    gp_finish = 0;
    check("t2_en_low", 64'(gp_en), 64'd0);
    check("t2_done", 64'(done_count), 64'd1);
    step(); step();

    // Three back-to-back commands, five-cycle engine latency
    base = int'(done_count);
    for (int i = 0; i < 3; i++) begin
      set_cmd(1, 10'(10 * i), 9'(i), 10'(10 * i + 5), 9'(i + 7), 12'(16'h100 + i));
      step();
    end
    drain(5);
    check("t3_done", 64'(done_count), 64'(base + 3));

    // Fill the FIFO with the engine stalled; next command is held
    k = 0;
    for (int i = 0; i < 40 && k < DEPTH + 1; i++) begin
      set_cmd(1, 10'(k), 9'd0, 10'(k + 1), 9'd1, 12'(k));
      step();
      if (m_pushed) k++;
    end
    set_cmd(0, 10'd100, 9'd100, 10'd200, 9'd200, 12'hABC);
    repeat (3) step();
    check("t4_ready_low", 64'(cmd_ready), 64'd0);
    check("t4_level_full", 64'(level), 64'(DEPTH));
    for (int i = 0; i < 100; i++) begin
      gp_finish = m_en && (m_age >= 1);
      step();
      if (m_pushed) break;
    end
    gp_finish = 0;
    cmd_valid = 0;
    check("t4_held_accepted", 64'(m_pushed), 64'd1);
    drain(1);

    // Invalid rectangles are consumed but not queued
    set_cmd(0, 10'd0, 9'd0, 10'd640, 9'd10, 12'h111);
    step();
    set_cmd(0, 10'd0, 9'd5, 10'd10, 9'd4, 12'h222);
    step();
    cmd_valid = 0;
    check("t5_level", 64'(level), 64'd0);
    check("t5_err_set", 64'(err_invalid), 64'd1);
    err_clr = 1;
    set_cmd(0, 10'd0, 9'd0, 10'd5, 9'd480, 12'h333);
    step();
    cmd_valid = 0;
    check("t5_err_clr_vs_push", 64'(err_invalid), 64'd1);
    step();
    err_clr = 0;
    check("t5_err_cleared", 64'(err_invalid), 64'd0);

    // Flush during RUN leaves the running command alone
    base = int'(done_count);
    for (int i = 0; i < 4; i++) begin
      set_cmd(0, 10'(i), 9'(i), 10'(i + 20), 9'(i + 20), 12'(i + 5));
      step();
    end
    cmd_valid = 0;
    step();
    flush = 1;
    step();
    flush = 0;
    check("t6_level", 64'(level), 64'd0);
    check("t6_en_kept", 64'(gp_en), 64'd1);
    drain(3);
    check("t6_done", 64'(done_count), 64'(base + 1));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cmd_valid  = ($urandom_range(0, 9) < 6);
      cmd_opcode = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        cmd_tl_x = 10'($urandom); cmd_tl_y = 9'($urandom);
        cmd_br_x = 10'($urandom); cmd_br_y = 9'($urandom);
      end else begin
        cmd_tl_x = 10'($urandom_range(0, 600));
        cmd_tl_y = 9'($urandom_range(0, 440));
        cmd_br_x = cmd_tl_x + 10'($urandom_range(0, 39));
        cmd_br_y = cmd_tl_y + 9'($urandom_range(0, 39));
      end
      cmd_arg   = 12'($urandom);
      flush     = ($urandom_range(0, 31) == 0);
      err_clr   = ($urandom_range(0, 19) == 0);
      gp_finish = m_en && ($urandom_range(0, 3) == 0);
      step();
    end
    flush = 0; err_clr = 0; gp_finish = 0;
    drain(2);

    // Asynchronous reset in the middle of a running command
    set_cmd(1, 10'd1, 9'd1, 10'd2, 9'd2, 12'h0AA);
    step();
    set_cmd(1, 10'd3, 9'd3, 10'd4, 9'd4, 12'h0BB);
    step();
    cmd_valid = 0;
    step(); step();
    check("t1_pre_en", 64'(gp_en), 64'd1);
    rst_n = 0;
    #1;
    model_reset();
    check("t1_rst_en", 64'(gp_en), 64'd0);
    check("t1_rst_level", 64'(level), 64'd0);
    check("t1_rst_ready", 64'(cmd_ready), 64'd1);
    check("t1_rst_done", 64'(done_count), 64'd0);
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1;
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
